// File: rtl/scatter_pkg.sv
// Shared definitions for the scatter crossbar.
// Holds the lane-count/width constants, the clog2 helper that sizes the
// lane-select field, and the round-robin pointer type.
// Configuration macro used by the crossbar: SCATTER_SRC_TAG_EN.
package scatter_pkg;

    // Ceiling log2, with 0 returned for values of 0 and 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned b = 0; b < 32; b++) begin
            if ((64'(1) << b) < 64'(v)) begin
                r = b + 1;
            end
        end
        return r;
    endfunction

    localparam int unsigned NUM_PES       = 32;
    localparam int unsigned IN_DATA_WIDTH = 16;
    // Must be at least LANE_SEL_W so that every output lane is addressable.
    localparam int unsigned INDEX_WIDTH   = 9;
    localparam int unsigned LANE_SEL_W    = clog2(NUM_PES);

    typedef logic [LANE_SEL_W-1:0] rr_ptr_t;

endpackage

// File: rtl/scatter_crossbar_rr_arbiter.sv
// Combinational round-robin arbiter for one crossbar output lane.
// Ports:
//   req       - one request bit per input lane
//   ptr       - input lane where the search starts
//   en        - arbitration enable (lane able to load)
//   gnt_c     - one-hot grant
//   gnt_idx_c - encoded grant index
//   any_c     - a grant was issued
module rr_arbiter
    import scatter_pkg::*;
(
    input  logic [NUM_PES-1:0] req,
    input  rr_ptr_t            ptr,
    input  logic               en,
    output logic [NUM_PES-1:0] gnt_c,
    output rr_ptr_t            gnt_idx_c,
    output logic               any_c
);

    // Scan from ptr upward, wrapping; the first requester wins.
    always_comb begin
        gnt_c     = '0;
        gnt_idx_c = '0;
        any_c     = 1'b0;
        for (int unsigned k = 0; k < NUM_PES; k++) begin
            int unsigned cand;
            rr_ptr_t     sel;
            cand = (int'(ptr) + k) % NUM_PES;
            sel  = LANE_SEL_W'(cand);
            if (en && !any_c && req[sel]) begin
                any_c      = 1'b1;
                gnt_c[sel] = 1'b1;
                gnt_idx_c  = sel;
            end
        end
    end

endmodule

// File: rtl/scatter_crossbar.sv
// Scatter crossbar: each input lane carries a word plus a destination
// output-lane index; words are routed to their output lane with per-lane
// round-robin arbitration and valid/ready flow control on both sides.
// Out-of-range indices are accepted, dropped, and flagged on o_err.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   i_valid      - per-input valid        o_ready    - per-input accept (comb)
//   i_data_bus   - input payloads         i_index_bus - destination lanes
//   o_valid      - per-output valid (reg) i_ready     - downstream ready
//   o_data_bus   - output payloads (reg)  o_err       - sticky bad-index flag
//   o_src_bus    - source lane per output word (only with SCATTER_SRC_TAG_EN)
module scatter_crossbar
    import scatter_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_PES-1:0]                 i_valid,
    output logic [NUM_PES-1:0]                 o_ready,
    input  logic [NUM_PES*IN_DATA_WIDTH-1:0]   i_data_bus,
    input  logic [NUM_PES*INDEX_WIDTH-1:0]     i_index_bus,
    output logic [NUM_PES-1:0]                 o_valid,
    input  logic [NUM_PES-1:0]                 i_ready,
    output logic [NUM_PES*IN_DATA_WIDTH-1:0]   o_data_bus,
    output logic                               o_err
`ifdef SCATTER_SRC_TAG_EN
    ,
    output logic [NUM_PES*INDEX_WIDTH-1:0]     o_src_bus
`endif
);

    localparam int unsigned N  = NUM_PES;
    localparam int unsigned DW = IN_DATA_WIDTH;
    localparam int unsigned XW = INDEX_WIDTH;

    logic [N-1:0][XW-1:0]  idx;
    rr_ptr_t [N-1:0]       dest;
    logic [N-1:0]          in_range;
    logic [N-1:0][N-1:0]   req;       // req[j][i]: input i wants output j
    logic [N-1:0]          arb_en;
    logic [N-1:0][N-1:0]   gnt;       // gnt[j][i]
    rr_ptr_t [N-1:0]       gnt_idx;
    logic [N-1:0]          gnt_any;

    rr_ptr_t [N-1:0]        rr_q, rr_d;
    logic [N-1:0]           o_valid_q, o_valid_d;
    logic [N-1:0][DW-1:0]   o_data_q, o_data_d;
    logic                   o_err_q, o_err_d;
`ifdef SCATTER_SRC_TAG_EN
    logic [N-1:0][XW-1:0]   o_src_q, o_src_d;
`endif

    // Index decode and request matrix; a lane may only arbitrate when it can load.
    always_comb begin
        idx      = '0;
        dest     = '0;
        in_range = '0;
        req      = '0;
        arb_en   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx[i]      = i_index_bus[i*XW +: XW];
            in_range[i] = idx[i] < XW'(N);
            dest[i]     = LANE_SEL_W'(idx[i]);
        end
        for (int unsigned j = 0; j < N; j++) begin
            for (int unsigned i = 0; i < N; i++) begin
                req[j][i] = i_valid[i] && in_range[i] && (dest[i] == LANE_SEL_W'(j));
            end
            arb_en[j] = !rst && (!o_valid_q[j] || i_ready[j]);
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_arb
        rr_arbiter u_arb (
            .req       (req[j]),
            .ptr       (rr_q[j]),
            .en        (arb_en[j]),
            .gnt_c     (gnt[j]),
            .gnt_idx_c (gnt_idx[j]),
            .any_c     (gnt_any[j])
        );
    end

    // Input accept: granted at its destination, or unconditionally when the index is invalid.
    always_comb begin
        o_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (rst) begin
                o_ready[i] = 1'b0;
            end else if (!in_range[i]) begin
                o_ready[i] = 1'b1;
            end else begin
                o_ready[i] = gnt[dest[i]][i];
            end
        end
    end

    // Output lane update; a grant replaces the current word even while it drains.
    always_comb begin
        rr_d      = rr_q;
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
`ifdef SCATTER_SRC_TAG_EN
        o_src_d   = o_src_q;
`endif
        o_err_d   = o_err_q | (|(i_valid & ~in_range));
        for (int unsigned j = 0; j < N; j++) begin
            if (gnt_any[j]) begin
                o_valid_d[j] = 1'b1;
                o_data_d[j]  = i_data_bus[int'(gnt_idx[j])*DW +: DW];
                rr_d[j]      = LANE_SEL_W'((int'(gnt_idx[j]) + 1) % N);
`ifdef SCATTER_SRC_TAG_EN
                o_src_d[j]   = XW'(gnt_idx[j]);
`endif
            end else if (i_ready[j]) begin
                o_valid_d[j] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q      <= '0;
            o_valid_q <= '0;
            o_data_q  <= '0;
            o_err_q   <= 1'b0;
`ifdef SCATTER_SRC_TAG_EN
            o_src_q   <= '0;
`endif
        end else begin
            rr_q      <= rr_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_err_q   <= o_err_d;
`ifdef SCATTER_SRC_TAG_EN
            o_src_q   <= o_src_d;
`endif
        end
    end

    assign o_valid    = o_valid_q;
    assign o_data_bus = o_data_q;
    assign o_err      = o_err_q;
`ifdef SCATTER_SRC_TAG_EN
    assign o_src_bus  = o_src_q;
`endif

endmodule

// File: tb/tb_scatter_crossbar.sv
// Self-checking bench for scatter_crossbar against a behavioural model
// that picks winners by smallest wrap-around distance from each lane's pointer.
module tb_scatter_crossbar;
    import scatter_pkg::*;

    localparam int N  = NUM_PES;
    localparam int DW = IN_DATA_WIDTH;
    localparam int XW = INDEX_WIDTH;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        i_valid;
    logic [N-1:0]        o_ready;
    logic [N*DW-1:0]     i_data_bus;
    logic [N*XW-1:0]     i_index_bus;
    logic [N-1:0]        o_valid;
    logic [N-1:0]        i_ready;
    logic [N*DW-1:0]     o_data_bus;
    logic                o_err;
`ifdef SCATTER_SRC_TAG_EN
    logic [N*XW-1:0]     o_src_bus;
`endif

    always #5 clk = ~clk;

    scatter_crossbar dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data_bus  (i_data_bus),
        .i_index_bus (i_index_bus),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data_bus  (o_data_bus),
        .o_err       (o_err)
`ifdef SCATTER_SRC_TAG_EN
        ,
        .o_src_bus   (o_src_bus)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Source/sink stimulus state
    logic          tv [N];
    logic [DW-1:0] td [N];
    int            tx [N];
    logic          tr [N];

    // Reference model state
    logic          m_valid [N];
    logic [DW-1:0] m_data  [N];
    int            m_rr    [N];
    int            m_src   [N];
    logic          m_err;
    int            win     [N];
    logic [N-1:0]  exp_ready;

    int   v0_count;
    logic track0;

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            i_valid[i]               = tv[i];
            i_data_bus[i*DW +: DW]   = td[i];
            i_index_bus[i*XW +: XW]  = XW'(tx[i]);
            i_ready[i]               = tr[i];
        end
    endtask

    // Winner per lane: the requester closest (ascending, wrapping) to the pointer.
    task automatic model_arbitrate();
        for (int j = 0; j < N; j++) begin
            int best;
            win[j] = -1;
            best   = N;
            if (!rst && (!m_valid[j] || tr[j])) begin
                for (int i = 0; i < N; i++) begin
                    if (tv[i] && tx[i] == j) begin
                        int d;
                        d = (i - m_rr[j] + N) % N;
                        if (d < best) begin
                            best   = d;
                            win[j] = i;
                        end
                    end
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (rst)           exp_ready[i] = 1'b0;
            else if (tx[i] >= N) exp_ready[i] = 1'b1;
            else               exp_ready[i] = (win[tx[i]] == i);
        end
    endtask

    task automatic model_clock();
        if (rst) begin
            for (int j = 0; j < N; j++) begin
                m_valid[j] = 1'b0; m_data[j] = '0; m_rr[j] = 0; m_src[j] = 0;
            end
            m_err = 1'b0;
        end else begin
            for (int i = 0; i < N; i++)
                if (tv[i] && tx[i] >= N) m_err = 1'b1;
            for (int j = 0; j < N; j++) begin
                if (win[j] >= 0) begin
                    m_valid[j] = 1'b1;
                    m_data[j]  = td[win[j]];
                    m_src[j]   = win[j];
                    m_rr[j]    = (win[j] + 1) % N;
                end else if (tr[j]) begin
                    m_valid[j] = 1'b0;
                end
            end
        end
    endtask

    // One clock cycle: check accepts mid-cycle, outputs just after the edge.
    task automatic step();
        logic [N-1:0]    ev;
        logic [N*DW-1:0] ed;
        logic [N-1:0]    acc;
        drive();
        #1;
        model_arbitrate();
        checks++;
        assert (o_ready === exp_ready)
            else begin errors++; $error("FAIL o_ready got=%h exp=%h", o_ready, exp_ready); end
        for (int i = 0; i < N; i++) acc[i] = tv[i] && exp_ready[i];
        @(posedge clk);
        model_clock();
        #1;
        for (int j = 0; j < N; j++) begin
            ev[j] = m_valid[j];
            ed[j*DW +: DW] = m_data[j];
        end
        checks++;
        assert (o_valid === ev)
            else begin errors++; $error("FAIL o_valid got=%h exp=%h", o_valid, ev); end
        checks++;
        assert (o_data_bus === ed)
            else begin errors++; $error("FAIL o_data got=%h exp=%h", o_data_bus, ed); end
        checks++;
        assert (o_err === m_err)
            else begin errors++; $error("FAIL o_err got=%b exp=%b", o_err, m_err); end
`ifdef SCATTER_SRC_TAG_EN
        begin
            logic [N*XW-1:0] es;
            for (int j = 0; j < N; j++) es[j*XW +: XW] = XW'(m_src[j]);
            checks++;
            assert (o_src_bus === es)
                else begin errors++; $error("FAIL o_src got=%h exp=%h", o_src_bus, es); end
        end
`endif
        if (track0 && o_valid[0]) v0_count++;
        for (int i = 0; i < N; i++) if (acc[i]) tv[i] = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            tv[i] = 1'b0; td[i] = '0; tx[i] = 0; tr[i] = 1'b1;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        track0 = 1'b0;
        v0_count = 0;
        m_err  = 1'b0;
        for (int j = 0; j < N; j++) begin
            m_valid[j] = 1'b0; m_data[j] = '0; m_rr[j] = 0; m_src[j] = 0;
        end
        clear_sources();
        drive();
        @(negedge clk);

        // Reset with valid sources present: nothing accepted, outputs zero
        for (int i = 0; i < N; i++) begin tv[i] = 1'b1; tx[i] = i; td[i] = DW'($urandom); end
        step();
        step();
        rst = 1'b0;

        // Identity routing, fresh words every cycle
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < N; i++) begin tv[i] = 1'b1; tx[i] = i; td[i] = DW'($urandom); end
            step();
        end
        step();

        // Full contention on lane 0
        clear_sources();
        pulse_reset();
        for (int i = 0; i < N; i++) begin tv[i] = 1'b1; tx[i] = 0; td[i] = DW'(i * 97 + 5); end
        track0 = 1'b1;
        v0_count = 0;
        repeat (N + 2) step();
        track0 = 1'b0;
        checks++;
        assert (v0_count == N)
            else begin errors++; $error("FAIL lane0_valid_cycles got=%0d exp=%0d", v0_count, N); end

        // Backpressure on lane 5 with inputs 3 and 7
        clear_sources();
        pulse_reset();
        tv[3] = 1'b1; tx[3] = 5; td[3] = 16'h0333;
        tv[7] = 1'b1; tx[7] = 5; td[7] = 16'h0777;
        tr[5] = 1'b0;
        repeat (5) step();
        tr[5] = 1'b1;
        repeat (2) step();
        // pointer now 8: input 9 must beat input 6
        tv[6] = 1'b1; tx[6] = 5; td[6] = 16'h0666;
        tv[9] = 1'b1; tx[9] = 5; td[9] = 16'h0999;
        repeat (3) step();

        // Out-of-range index: accepted, dropped, sticky error
        clear_sources();
        tv[2] = 1'b1; tx[2] = 40; td[2] = 16'hbad0;
        step();
        repeat (3) step();
        checks++;
        assert (o_err === 1'b1)
            else begin errors++; $error("FAIL err_sticky got=%b exp=1", o_err); end

        // Reset while lanes 0-3 hold stalled words
        clear_sources();
        for (int i = 0; i < 4; i++) begin tv[i] = 1'b1; tx[i] = i; td[i] = DW'($urandom); tr[i] = 1'b0; end
        step();
        step();
        clear_sources();
        pulse_reset();
        tv[0] = 1'b1;  tx[0] = 1;  td[0] = 16'h1000;
        tv[20] = 1'b1; tx[20] = 1; td[20] = 16'h2000;
        repeat (3) step();

`ifdef SCATTER_SRC_TAG_EN
        clear_sources();
        tv[9] = 1'b1; tx[9] = 4; td[9] = 16'h4949;
        step();
        checks++;
        assert (o_src_bus[4*XW +: XW] === XW'(9) && o_valid[4] === 1'b1)
            else begin errors++; $error("FAIL src_tag got=%0d exp=9", o_src_bus[4*XW +: XW]); end
`endif

        // Randomized traffic with hot lanes, backpressure, bad indices and rare resets
        clear_sources();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++) begin
                if (!tv[i] && ($urandom_range(0, 1) == 1)) begin
                    tv[i] = 1'b1;
                    td[i] = DW'($urandom);
                    if ($urandom_range(0, 15) == 0)     tx[i] = N + $urandom_range(0, 479);
                    else if ($urandom_range(0, 1) == 0) tx[i] = $urandom_range(0, 3);
                    else                                tx[i] = $urandom_range(0, N - 1);
                end
            end
            for (int j = 0; j < N; j++) tr[j] = ($urandom_range(0, 3) != 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
